uart_rx_result_arbiter: RTL and testbench

Round-robin arbiter that shares one UART receive-result channel between `NUM_REQ` receiver lanes. Each lane delivers beats of data (`out`/`valid_out`) and status (`error`/`valid_error`) with no backpressure. The block buffers one beat per lane and serializes the beats onto a single registered output channel, with a downstream `ready` handshake and a source-lane tag. It sits between the per-lane UART receivers and the shared result consumer (FIFO/bus bridge).

---
 rtl/uart_rx_result_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_result_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_result_arbiter.sv
// Round-robin arbiter serializing NUM_REQ UART receiver result lanes onto one registered, ready-handshaked channel.
// Optional overrun flagging/counting is built when UART_ARB_OVERRUN_EN is defined.
module uart_rx_result_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH_DATABITS = 8,
    parameter int WIDTH_ERROR    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*WIDTH_DATABITS-1:0] req_out,
    input  logic [NUM_REQ-1:0]                req_valid_out,
    input  logic [NUM_REQ*WIDTH_ERROR-1:0]    req_error,
    input  logic [NUM_REQ-1:0]                req_valid_error,
    input  logic                              ready,
    output logic [WIDTH_DATABITS-1:0]         out,
    output logic                              valid_out,
    output logic [WIDTH_ERROR-1:0]            error,
    output logic                              valid_error,
    output logic [$clog2(NUM_REQ)-1:0]        src_id
`ifdef UART_ARB_OVERRUN_EN
    ,
    output logic [15:0]                       overrun_cnt
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                            state_q, state_d;
    logic [NUM_REQ-1:0]                full_q, full_d;
    logic [NUM_REQ-1:0]                svo_q, svo_d;
    logic [NUM_REQ-1:0]                sve_q, sve_d;
    logic [NUM_REQ*WIDTH_DATABITS-1:0] sdata_q, sdata_d;
    logic [NUM_REQ*WIDTH_ERROR-1:0]    serr_q, serr_d;
    logic [IDW-1:0]                    ptr_q, ptr_d;
    logic [WIDTH_DATABITS-1:0]         out_q, out_d;
    logic [WIDTH_ERROR-1:0]            err_q, err_d;
    logic                              vo_q, vo_d;
    logic                              ve_q, ve_d;
    logic [IDW-1:0]                    src_q, src_d;

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           do_grant;

    // Scan offsets from the highest down so the lowest offset from ptr wins.
    always_comb begin
        logic [IDW:0] pos;
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (IDW+1)'(k);
            if (pos >= NREQ_W) begin
                pos = pos - NREQ_W;
            end
            if (full_q[pos[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        out_d    = out_q;
        err_d    = err_q;
        vo_d     = vo_q;
        ve_d     = ve_q;
        src_d    = src_q;
        do_grant = 1'b0;
        case (state_q)
            IDLE: begin
                do_grant = gnt_any;
            end
            PRESENT: begin
                if (ready) begin
                    if (gnt_any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        vo_d    = 1'b0;
                        ve_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_grant) begin
            state_d = PRESENT;
            src_d   = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_idx == IDW'(k)) begin
                    out_d = sdata_q[k*WIDTH_DATABITS +: WIDTH_DATABITS];
                    err_d = serr_q[k*WIDTH_ERROR +: WIDTH_ERROR];
                    vo_d  = svo_q[k];
                    ve_d  = sve_q[k];
                end
            end
        end
    end

`ifdef UART_ARB_OVERRUN_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [4:0]  ovr_num;
    logic [16:0] cnt_sum;
`endif

    // A drained slot may be refilled in the same edge; only a beat on an undrained FULL slot is an overrun.
    always_comb begin
        logic beat;
        logic drained;
        full_d  = full_q;
        svo_d   = svo_q;
        sve_d   = sve_q;
        sdata_d = sdata_q;
        serr_d  = serr_q;
        beat    = 1'b0;
        drained = 1'b0;
`ifdef UART_ARB_OVERRUN_EN
        ovr_num = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            beat    = req_valid_out[i] | req_valid_error[i];
            drained = do_grant && (gnt_idx == IDW'(i));
            if (drained) begin
                full_d[i] = 1'b0;
                svo_d[i]  = 1'b0;
                sve_d[i]  = 1'b0;
            end
            if (beat && (!full_q[i] || drained)) begin
                full_d[i] = 1'b1;
                svo_d[i]  = req_valid_out[i];
                sve_d[i]  = req_valid_error[i];
                sdata_d[i*WIDTH_DATABITS +: WIDTH_DATABITS] =
                    req_valid_out[i] ? req_out[i*WIDTH_DATABITS +: WIDTH_DATABITS] : '0;
                serr_d[i*WIDTH_ERROR +: WIDTH_ERROR] =
                    req_valid_error[i] ? req_error[i*WIDTH_ERROR +: WIDTH_ERROR] : '0;
            end
`ifdef UART_ARB_OVERRUN_EN
            else if (beat) begin
                full_d[i] = 1'b1;
                svo_d[i]  = req_valid_out[i];
                sve_d[i]  = 1'b1;
                sdata_d[i*WIDTH_DATABITS +: WIDTH_DATABITS] =
                    req_valid_out[i] ? req_out[i*WIDTH_DATABITS +: WIDTH_DATABITS] : '0;
                serr_d[i*WIDTH_ERROR +: WIDTH_ERROR] =
                    req_valid_error[i] ? req_error[i*WIDTH_ERROR +: WIDTH_ERROR] : '0;
                serr_d[i*WIDTH_ERROR] = 1'b1;
                ovr_num = ovr_num + 5'd1;
            end
`endif
        end
    end

`ifdef UART_ARB_OVERRUN_EN
    always_comb begin
        cnt_sum   = {1'b0, ovr_cnt_q} + 17'(ovr_num);
        ovr_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            full_q  <= '0;
            svo_q   <= '0;
            sve_q   <= '0;
            sdata_q <= '0;
            serr_q  <= '0;
            ptr_q   <= '0;
            out_q   <= '0;
            err_q   <= '0;
            vo_q    <= 1'b0;
            ve_q    <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            svo_q   <= svo_d;
            sve_q   <= sve_d;
            sdata_q <= sdata_d;
            serr_q  <= serr_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            err_q   <= err_d;
            vo_q    <= vo_d;
            ve_q    <= ve_d;
            src_q   <= src_d;
        end
    end

    assign out         = out_q;
    assign error       = err_q;
    assign valid_out   = vo_q;
    assign valid_error = ve_q;
    assign src_id      = src_q;

endmodule

// File: tb/tb_uart_rx_result_arbiter.sv
// Scoreboard bench for uart_rx_result_arbiter (4 lanes, 8 data bits, 3 error bits).
module tb_uart_rx_result_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int EW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] req_out = '0;
    logic [N-1:0]    req_valid_out = '0;
    logic [N*EW-1:0] req_error = '0;
    logic [N-1:0]    req_valid_error = '0;
    logic            ready = 1'b0;
    logic [DW-1:0]   out;
    logic            valid_out;
    logic [EW-1:0]   error;
    logic            valid_error;
    logic [1:0]      src_id;
`ifdef UART_ARB_OVERRUN_EN
    logic [15:0]     overrun_cnt;
`endif

    uart_rx_result_arbiter #(.NUM_REQ(N), .WIDTH_DATABITS(DW), .WIDTH_ERROR(EW)) dut (
        .clk(clk), .rst(rst),
        .req_out(req_out), .req_valid_out(req_valid_out),
        .req_error(req_error), .req_valid_error(req_valid_error),
        .ready(ready),
        .out(out), .valid_out(valid_out), .error(error), .valid_error(valid_error),
        .src_id(src_id)
`ifdef UART_ARB_OVERRUN_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] s, input logic [7:0] d,
                                         input logic [2:0] e, input logic vo, input logic ve);
        return {17'b0, s, d, e, vo, ve};
    endfunction

    // Transfers are taken mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!rst && (valid_out || valid_error) && ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", pack(src_id, out, error, valid_out, valid_error), 32'h0);
            end else begin
                chk("beat", pack(src_id, out, error, valid_out, valid_error), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_out = '0; req_valid_out = '0; req_error = '0; req_valid_error = '0;
    endtask

    task automatic lane(input int i, input logic [7:0] d, input logic [2:0] e,
                        input logic vo, input logic ve);
        req_out[i*DW +: DW]  = d;
        req_error[i*EW +: EW] = e;
        req_valid_out[i]     = vo;
        req_valid_error[i]   = ve;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_out || valid_error) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
        chk({tag, "_idle"}, {valid_out, valid_error}, 0);
        exp_q.delete();
    endtask

    initial begin
        // Reset with garbage on every input
        rst = 1'b1;
        req_out = $urandom; req_error = $urandom;
        req_valid_out = 4'hF; req_valid_error = $urandom; ready = 1'b1;
        repeat (3) tick();
        chk("in_rst_vo", valid_out, 0);
        clear_in();
        ready = 1'b0;
        rst   = 1'b0;
        tick();
        chk("rst_out", out, 0);
        chk("rst_err", error, 0);
        chk("rst_valids", {valid_out, valid_error}, 0);
        chk("rst_src", src_id, 0);
        chk("rst_ptr", dut.ptr_q, 0);
`ifdef UART_ARB_OVERRUN_EN
        chk("rst_ovr", overrun_cnt, 0);
`endif

        // Latency and unused-field zeroing: lane 2 data-only beat
        lane(2, 8'hA5, 3'b101, 1'b1, 1'b0);
        tick();
        clear_in();
        chk("lat_early", valid_out, 0);
        tick();
        chk("lat_out", out, 8'hA5);
        chk("lat_src", src_id, 2);
        chk("lat_valids", {valid_out, valid_error}, 2'b10);
        chk("lat_err_zero", error, 0);
        exp_q.push_back(pack(2, 8'hA5, 0, 1, 0));
        ready = 1'b1;
        wait_drain("drain_lat", 20);

        // Round robin: all four lanes at once, ptr currently 3
        for (int i = 0; i < N; i++) lane(i, 8'h10 + 8'(i), 3'(i + 1), 1'b1, 1'b1);
        exp_q.push_back(pack(3, 8'h13, 3'd4, 1, 1));
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(2'(i), 8'h10 + 8'(i), 3'(i + 1), 1, 1));
        tick();
        clear_in();
        wait_drain("drain_rr4", 20);

        // ptr is now 3: lanes 0 and 3 -> 3 first, then lane 0 refilled after its grant
        lane(0, 8'h20, 0, 1'b1, 1'b0);
        lane(3, 8'h23, 0, 1'b1, 1'b0);
        exp_q.push_back(pack(3, 8'h23, 0, 1, 0));
        exp_q.push_back(pack(0, 8'h20, 0, 1, 0));
        exp_q.push_back(pack(0, 8'h24, 0, 1, 0));
        tick();
        clear_in();
        tick();
        tick();
        lane(0, 8'h24, 0, 1'b1, 1'b0);
        tick();
        clear_in();
        wait_drain("drain_rr2", 20);

        // Backpressure hold
        ready = 1'b0;
        lane(1, 8'h3C, 3'b010, 1'b1, 1'b1);
        tick();
        clear_in();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_out", out, 8'h3C);
            chk("bp_meta", {src_id, valid_out, valid_error, error}, {2'd1, 1'b1, 1'b1, 3'b010});
            tick();
        end
        exp_q.push_back(pack(1, 8'h3C, 3'b010, 1, 1));
        ready = 1'b1;
        tick();
        chk("bp_idle", {valid_out, valid_error}, 0);
        chk("bp_q", exp_q.size(), 0);

        // Same-cycle drain and refill on lane 0, full throughput
        for (int i = 0; i < 12; i++) begin
            lane(0, 8'h40 + 8'(i), 0, 1'b1, 1'b0);
            exp_q.push_back(pack(0, 8'h40 + 8'(i), 0, 1, 0));
            tick();
            if (i >= 1) chk("refill_vo", valid_out, 1);
        end
        clear_in();
        wait_drain("drain_refill", 20);
`ifdef UART_ARB_OVERRUN_EN
        chk("refill_ovr", overrun_cnt, 0);
`endif

        // Overrun on lane 3 while output is stalled
        ready = 1'b0;
        lane(3, 8'h01, 0, 1'b1, 1'b0);
        tick();
        clear_in();
        tick();
        chk("ovr_first", {src_id, out}, {2'd3, 8'h01});
        lane(3, 8'hEE, 0, 1'b1, 1'b0);
        tick();
        lane(3, 8'h02, 0, 1'b1, 1'b0);
        tick();
        clear_in();
        tick();
        chk("ovr_hold", {src_id, out, valid_out}, {2'd3, 8'h01, 1'b1});
        exp_q.push_back(pack(3, 8'h01, 0, 1, 0));
`ifdef UART_ARB_OVERRUN_EN
        exp_q.push_back(pack(3, 8'h02, 3'b001, 1, 1));
`else
        exp_q.push_back(pack(3, 8'hEE, 0, 1, 0));
`endif
        ready = 1'b1;
        wait_drain("drain_ovr", 20);
`ifdef UART_ARB_OVERRUN_EN
        chk("ovr_cnt", overrun_cnt, 1);
`endif

        // Mid-operation reset: one beat presented, three slots pending
        ready = 1'b0;
        for (int i = 0; i < N; i++) lane(i, 8'h80 + 8'(i), 0, 1'b1, 1'b0);
        tick();
        clear_in();
        tick();
        chk("mid_pres", valid_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_outs", {out, error, valid_out, valid_error, src_id}, 0);
        tick();
        chk("mid_after", {valid_out, valid_error}, 0);
        chk("mid_ptr", dut.ptr_q, 0);
        ready = 1'b1;
        repeat (8) tick();
        chk("mid_no_stale", {valid_out, valid_error}, 0);
        chk("mid_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
